// File: rtl/seg_counter_display.sv
// Two-digit BCD up/down counter driven by debounced button levels, with a
// time-multiplexed common-anode 7-segment display (active-low seg and an).
module seg_counter_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] count_out,
    output logic       step,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int              CW          = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   REFRESH_MAX = CW'(REFRESH_DIV - 1);

    logic          up_prev_q, down_prev_q;
    logic          up_evt_q, up_evt_d;
    logic          down_evt_q, down_evt_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic          step_q, step_d;
    logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic          digit_sel_q, digit_sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          inc, dec, wrap;
    logic [3:0]    shown;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Events are registered first, so the count moves one edge after the rising level is seen.
    assign up_evt_d   = btn_up & ~up_prev_q;
    assign down_evt_d = btn_down & ~down_prev_q;
    assign inc        = up_evt_q & ~down_evt_q;
    assign dec        = down_evt_q & ~up_evt_q;
    assign step_d     = inc | dec;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (inc) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (dec) begin
            if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    assign wrap          = (refresh_cnt_q == REFRESH_MAX);
    assign refresh_cnt_d = wrap ? '0 : refresh_cnt_q + 1'b1;
    assign digit_sel_d   = digit_sel_q ^ wrap;

    // Display registers sample the current count/select, adding one edge of latency.
    assign shown = digit_sel_q ? tens_q : ones_q;
    assign seg_d = seg_decode(shown);
    assign an_d  = digit_sel_q ? 2'b01 : 2'b10;

    always_ff @(posedge clk) begin
        if (rst) begin
            up_prev_q     <= 1'b0;
            down_prev_q   <= 1'b0;
            up_evt_q      <= 1'b0;
            down_evt_q    <= 1'b0;
            ones_q        <= 4'd0;
            tens_q        <= 4'd0;
            step_q        <= 1'b0;
            refresh_cnt_q <= '0;
            digit_sel_q   <= 1'b0;
            seg_q         <= 7'b1000000;
            an_q          <= 2'b10;
        end else begin
            up_prev_q     <= btn_up;
            down_prev_q   <= btn_down;
            up_evt_q      <= up_evt_d;
            down_evt_q    <= down_evt_d;
            ones_q        <= ones_d;
            tens_q        <= tens_d;
            step_q        <= step_d;
            refresh_cnt_q <= refresh_cnt_d;
            digit_sel_q   <= digit_sel_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign count_out = {tens_q, ones_q};
    assign step      = step_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

// File: tb/tb_seg_counter_display.sv
// Randomized and directed bench for seg_counter_display against an
// integer-arithmetic reference model of count, step and display.
module tb_seg_counter_display;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [7:0] count_out;
    logic       step;
    logic [6:0] seg;
    logic [1:0] an;

    int n_cmp = 0;
    int n_bad = 0;

    seg_counter_display #(.REFRESH_DIV(R)) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
        .count_out(count_out), .step(step), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference model: count as an integer 0..99, pending delta, and a
    // cycle-counted display phase.
    int         m_cnt = 0, m_pend = 0, m_step = 0, m_pu = 0, m_pd = 0, m_rc = 0, m_dsel = 0;
    logic [6:0] m_seg = 7'b1000000;
    logic [1:0] m_an = 2'b10;

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_pend = 0; m_step = 0; m_pu = 0; m_pd = 0; m_rc = 0; m_dsel = 0;
            m_seg = seg_tbl[0];
            m_an  = 2'b10;
        end else begin
            m_seg  = seg_tbl[m_dsel != 0 ? m_cnt / 10 : m_cnt % 10];
            m_an   = (m_dsel != 0) ? 2'b01 : 2'b10;
            m_step = (m_pend != 0) ? 1 : 0;
            m_cnt  = (m_cnt + m_pend + 100) % 100;
            m_pend = ((btn_up && m_pu == 0) ? 1 : 0) - ((btn_down && m_pd == 0) ? 1 : 0);
            m_pu   = btn_up ? 1 : 0;
            m_pd   = btn_down ? 1 : 0;
            if (m_rc == R - 1) begin
                m_rc   = 0;
                m_dsel = 1 - m_dsel;
            end else begin
                m_rc = m_rc + 1;
            end
        end
    end

    int pulses;

    task automatic tick();
        @(negedge clk);
        if (step === 1'b1) pulses++;
    endtask

    task automatic press_up();
        btn_up = 1'b1; tick(); tick();
        btn_up = 1'b0; tick(); tick();
    endtask

    task automatic press_down();
        btn_down = 1'b1; tick(); tick();
        btn_down = 1'b0; tick(); tick();
    endtask

    task automatic goto_count(input int target);
        int guard = 0;
        while (m_cnt != target && guard < 120) begin
            press_up();
            guard++;
        end
        n_cmp++;
        if (count_out !== bcd(target)) begin
            n_bad++;
            $display("FAIL goto_count: got %h want %h", count_out, bcd(target));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({count_out, step, an, seg} !== {8'h00, 1'b0, 2'b10, 7'b1000000}) begin
            n_bad++;
            $display("FAIL reset_state: count=%h step=%b an=%b seg=%b", count_out, step, an, seg);
        end
        rst = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            logic [1:0] exp_an;
            tick();
            exp_an = (((k - 1) / R) % 2 != 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if (an !== exp_an) begin
                n_bad++;
                $display("FAIL reset_an_toggle k=%0d: got %b want %b", k, an, exp_an);
            end
        end
    endtask

    task automatic test_held_press();
        pulses = 0;
        btn_up = 1'b1;
        repeat (100) tick();
        btn_up = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (count_out !== 8'h01) begin
            n_bad++;
            $display("FAIL held_count: got %h want 01", count_out);
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL held_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_simultaneous();
        int c0 = m_cnt;
        pulses = 0;
        btn_up = 1'b1; btn_down = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (count_out !== bcd(c0) || pulses != 0) begin
            n_bad++;
            $display("FAIL simul_both: count=%h pulses=%0d want %h/0", count_out, pulses, bcd(c0));
        end
        btn_down = 1'b0; tick(); tick();
        btn_down = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (count_out !== bcd((c0 + 99) % 100) || pulses != 1) begin
            n_bad++;
            $display("FAIL simul_down_while_up: count=%h pulses=%0d want %h/1",
                     count_out, pulses, bcd((c0 + 99) % 100));
        end
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_carry_wrap();
        rst = 1'b1; tick(); rst = 1'b0;
        pulses = 0;
        repeat (10) press_up();
        n_cmp++;
        if (count_out !== 8'h10 || pulses != 10) begin
            n_bad++;
            $display("FAIL carry_to_10: count=%h pulses=%0d want 10/10", count_out, pulses);
        end
        goto_count(99);
        pulses = 0;
        press_up();
        n_cmp++;
        if (count_out !== 8'h00 || pulses != 1) begin
            n_bad++;
            $display("FAIL wrap_99_to_00: count=%h pulses=%0d want 00/1", count_out, pulses);
        end
        pulses = 0;
        press_down();
        n_cmp++;
        if (count_out !== 8'h99 || pulses != 1) begin
            n_bad++;
            $display("FAIL wrap_00_to_99: count=%h pulses=%0d want 99/1", count_out, pulses);
        end
        // Alternate-cycle events must all be applied.
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            btn_up = (i % 2 == 0); tick();
        end
        btn_up = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (count_out !== 8'h02 || pulses != 3) begin
            n_bad++;
            $display("FAIL back_to_back: count=%h pulses=%0d want 02/3", count_out, pulses);
        end
    endtask

    task automatic test_display_42();
        int toggles = 0;
        logic [1:0] last_an;
        goto_count(42);
        tick();
        last_an = an;
        for (int i = 0; i < 20 * R; i++) begin
            tick();
            if (an !== last_an) toggles++;
            last_an = an;
            n_cmp++;
            if (!((an === 2'b10 && seg === 7'b0100100) || (an === 2'b01 && seg === 7'b0011001))) begin
                n_bad++;
                $display("FAIL display_42 i=%0d: an=%b seg=%b", i, an, seg);
            end
        end
        n_cmp++;
        if (toggles != 20) begin
            n_bad++;
            $display("FAIL display_toggles: got %0d want 20", toggles);
        end
    endtask

    task automatic test_reset_mid_press();
        goto_count(57);
        pulses = 0;
        btn_up = 1'b1; tick();
        rst = 1'b1; tick();
        n_cmp++;
        if ({count_out, step, an, seg} !== {8'h00, 1'b0, 2'b10, 7'b1000000}) begin
            n_bad++;
            $display("FAIL midrst_state: count=%h step=%b an=%b seg=%b", count_out, step, an, seg);
        end
        rst = 1'b0;
        pulses = 0;
        tick();
        n_cmp++;
        if (count_out !== 8'h00 || step !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_edge1: count=%h step=%b want 00/0", count_out, step);
        end
        tick();
        n_cmp++;
        if (count_out !== 8'h01 || step !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_edge2: count=%h step=%b want 01/1", count_out, step);
        end
        repeat (6) tick();
        btn_up = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (count_out !== 8'h01 || pulses != 1) begin
            n_bad++;
            $display("FAIL midrst_settle: count=%h pulses=%0d want 01/1", count_out, pulses);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0) btn_up = ~btn_up;
            if ($urandom_range(2) == 0) btn_down = ~btn_down;
            if ($urandom_range(99) == 0) rst = 1'b1;
            else rst = 1'b0;
            tick();
            n_cmp++;
            if (count_out !== bcd(m_cnt) || step !== m_step[0] || seg !== m_seg || an !== m_an) begin
                n_bad++;
                $display("FAIL random i=%0d: got %h/%b/%b/%b want %h/%0d/%b/%b",
                         i, count_out, step, seg, an, bcd(m_cnt), m_step, m_seg, m_an);
            end
        end
        rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    endtask

    initial begin
        pulses = 0;
        test_reset();
        test_held_press();
        test_simultaneous();
        test_carry_wrap();
        test_display_42();
        test_reset_mid_press();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
